// File: rtl/video_pattern_gen.sv
// -----------------------------------------------------------------------------
// video_pattern_gen
//   Parametrised test-pattern source. Emits one 24-bit {R,G,B} pixel per
//   VideoReady beat over an H_ACTIVE x V_ACTIVE raster, using one of four
//   patterns (HBARS, VBARS, CHECKER, SOLID). The requested Mode is latched
//   only when the last pixel of a frame is consumed, so a frame never mixes
//   patterns.
//
//   Optional feature macro: PATGEN_BORDER_EN
//     When defined, a one-pixel white (24'hFFFFFF) border overrides the
//     pattern on the outer rows and columns. Stripe counters keep advancing
//     underneath, so the pattern inside the border is unchanged.
//
// Ports
//   Clock        in   1   system clock, all logic on posedge
//   Reset        in   1   synchronous, active-high
//   VideoReady   in   1   sink consumes the current pixel at this posedge
//   Mode         in   2   requested pattern: 0 HBARS, 1 VBARS, 2 CHECKER, 3 SOLID
//   video        out  24  current pixel {R,G,B}
//   StartOfFrame out  1   current pixel is (col 0, row 0)
//   EndOfLine    out  1   current pixel is col H_ACTIVE-1
//   FrameCount   out  8   completed frames, modulo 256
// -----------------------------------------------------------------------------
module video_pattern_gen #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int STRIPE   = 80
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        VideoReady,
  input  logic [1:0]  Mode,
  output logic [23:0] video,
  output logic        StartOfFrame,
  output logic        EndOfLine,
  output logic [7:0]  FrameCount
);

  localparam int CW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int RW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int SW = (STRIPE   > 1) ? $clog2(STRIPE)   : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(H_ACTIVE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_ACTIVE - 1);
  localparam logic [SW-1:0] SUB_LAST = SW'(STRIPE - 1);

  localparam logic [23:0] TURQUOISE   = 24'h1ABC9C;
  localparam logic [23:0] CARROT      = 24'hE67E22;
  localparam logic [23:0] SUNFLOWER   = 24'hF1C40F;
  localparam logic [23:0] POMEGRANATE = 24'hC0392B;

  typedef enum logic [1:0] {
    HBARS   = 2'd0,
    VBARS   = 2'd1,
    CHECKER = 2'd2,
    SOLID   = 2'd3
  } mode_e;

  function automatic logic [23:0] palette(input logic [1:0] idx);
    case (idx)
      2'd0:    palette = TURQUOISE;
      2'd1:    palette = CARROT;
      2'd2:    palette = SUNFLOWER;
      default: palette = POMEGRANATE;
    endcase
  endfunction

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [SW-1:0] col_sub_q, col_sub_d;
  logic [SW-1:0] row_sub_q, row_sub_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [7:0]    frame_count_q, frame_count_d;
  mode_e         active_mode_q, active_mode_d;

  // Next-state: raster position plus stripe sub-counters. The sub-counters
  // replace a divide by STRIPE; each wrap bumps the 2-bit stripe index.
  always_comb begin
    col_d         = col_q;
    row_d         = row_q;
    col_sub_d     = col_sub_q;
    row_sub_d     = row_sub_q;
    col_idx_d     = col_idx_q;
    row_idx_d     = row_idx_q;
    frame_count_d = frame_count_q;
    active_mode_d = active_mode_q;

    if (VideoReady) begin
      if (col_q == COL_LAST) begin
        // Stripes restart at every line.
        col_d     = '0;
        col_sub_d = '0;
        col_idx_d = '0;
        if (row_q == ROW_LAST) begin
          // Frame wrap: the only point where a new Mode is accepted.
          row_d         = '0;
          row_sub_d     = '0;
          row_idx_d     = '0;
          frame_count_d = frame_count_q + 8'd1;
          active_mode_d = mode_e'(Mode);
        end else begin
          row_d = row_q + RW'(1);
          if (row_sub_q == SUB_LAST) begin
            row_sub_d = '0;
            row_idx_d = row_idx_q + 2'd1;
          end else begin
            row_sub_d = row_sub_q + SW'(1);
          end
        end
      end else begin
        col_d = col_q + CW'(1);
        if (col_sub_q == SUB_LAST) begin
          col_sub_d = '0;
          col_idx_d = col_idx_q + 2'd1;
        end else begin
          col_sub_d = col_sub_q + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      col_q         <= '0;
      row_q         <= '0;
      col_sub_q     <= '0;
      row_sub_q     <= '0;
      col_idx_q     <= '0;
      row_idx_q     <= '0;
      frame_count_q <= '0;
      active_mode_q <= HBARS;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      col_sub_q     <= col_sub_d;
      row_sub_q     <= row_sub_d;
      col_idx_q     <= col_idx_d;
      row_idx_q     <= row_idx_d;
      frame_count_q <= frame_count_d;
      active_mode_q <= active_mode_d;
    end
  end

  // Pixel colour is decoded straight from the registered counters, so the
  // output describes the pixel at the current position with no latency.
  always_comb begin
    video = TURQUOISE;
    case (active_mode_q)
      HBARS:   video = palette(row_idx_q);
      VBARS:   video = palette(col_idx_q);
      CHECKER: video = (col_idx_q[0] ^ row_idx_q[0]) ? CARROT : TURQUOISE;
      SOLID:   video = palette(frame_count_q[1:0]);
      default: video = TURQUOISE;
    endcase
`ifdef PATGEN_BORDER_EN
    if ((row_q == '0) || (row_q == ROW_LAST) || (col_q == '0) || (col_q == COL_LAST)) begin
      video = 24'hFFFFFF;
    end
`else
`endif
  end

  assign StartOfFrame = (col_q == '0) && (row_q == '0);
  assign EndOfLine    = (col_q == COL_LAST);
  assign FrameCount   = frame_count_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_video_pattern_gen
//   Directed bench for video_pattern_gen with an 8x4 raster and 2-pixel
//   stripes. A position/frame model tracks the expected pixel per beat.
// -----------------------------------------------------------------------------
module tb_video_pattern_gen;

  localparam int H = 8;
  localparam int V = 4;
  localparam int S = 2;

  localparam logic [23:0] P0 = 24'h1ABC9C;
  localparam logic [23:0] P1 = 24'hE67E22;
  localparam logic [23:0] P2 = 24'hF1C40F;
  localparam logic [23:0] P3 = 24'hC0392B;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        VideoReady;
  logic [1:0]  Mode;
  logic [23:0] video;
  logic        StartOfFrame;
  logic        EndOfLine;
  logic [7:0]  FrameCount;

  video_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .STRIPE(S)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .VideoReady   (VideoReady),
    .Mode         (Mode),
    .video        (video),
    .StartOfFrame (StartOfFrame),
    .EndOfLine    (EndOfLine),
    .FrameCount   (FrameCount)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: position of the current pixel, frame count, active mode.
  int m_col  = 0;
  int m_row  = 0;
  int m_fc   = 0;
  int m_mode = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (row %0d col %0d frame %0d)",
                  tag, got, exp, m_row, m_col, m_fc);
  endtask

  function automatic logic [23:0] pal(input int i);
    case (i % 4)
      0:       pal = P0;
      1:       pal = P1;
      2:       pal = P2;
      default: pal = P3;
    endcase
  endfunction

  function automatic logic [23:0] exp_pix();
    logic [23:0] p;
    case (m_mode)
      0:       p = pal(m_row / S);
      1:       p = pal(m_col / S);
      2:       p = (((m_col / S) % 2) != ((m_row / S) % 2)) ? P1 : P0;
      default: p = pal(m_fc);
    endcase
`ifdef PATGEN_BORDER_EN
    if (m_row == 0 || m_row == V - 1 || m_col == 0 || m_col == H - 1) p = 24'hFFFFFF;
`endif
    return p;
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_video"}, 32'(video), 32'(exp_pix()));
    check({tag, "_sof"},   32'(StartOfFrame), 32'((m_row == 0) && (m_col == 0)));
    check({tag, "_eol"},   32'(EndOfLine), 32'(m_col == H - 1));
    check({tag, "_fc"},    32'(FrameCount), 32'(m_fc % 256));
  endtask

  // One clock with the given VideoReady/Mode; model follows the DUT rules.
  task automatic beat(input logic rdy, input logic [1:0] md, input bit chk, input string tag);
    VideoReady = rdy;
    Mode       = md;
    @(posedge Clock);
    #1;
    if (rdy) begin
      if (m_col == H - 1) begin
        m_col = 0;
        if (m_row == V - 1) begin
          m_row  = 0;
          m_fc   = (m_fc + 1) % 256;
          m_mode = int'(md);
        end else begin
          m_row++;
        end
      end else begin
        m_col++;
      end
    end
    if (chk) check_all(tag);
  endtask

  task automatic reset_model();
    m_col = 0; m_row = 0; m_fc = 0; m_mode = 0;
  endtask

  initial begin
    Reset      = 1'b1;
    VideoReady = 1'b1;
    Mode       = 2'd2;
    repeat (3) @(posedge Clock);
    #1;
    // Reset holds the raster at origin even with VideoReady high, ActiveMode HBARS.
    reset_model();
`ifdef PATGEN_BORDER_EN
    check("rst_video", 32'(video), 32'h00FFFFFF);
`else
    check("rst_video", 32'(video), 32'(P0));
`endif
    check("rst_sof", 32'(StartOfFrame), 32'd1);
    check("rst_eol", 32'(EndOfLine), 32'd0);
    check("rst_fc",  32'(FrameCount), 32'd0);
    Reset = 1'b0;

    // Reset mid-frame at row 2 col 5 (21 beats in).
    for (int i = 0; i < 21; i++) beat(1'b1, 2'd0, 1'b1, "pre6");
    check("t6_pos_eol", 32'(EndOfLine), 32'd0);
    Reset = 1'b1;
    beat(1'b1, 2'd0, 1'b0, "t6");
    Reset = 1'b0;
    reset_model();
    check_all("t6");
`ifndef PATGEN_BORDER_EN
    check("t6_p0", 32'(video), 32'(P0));
`endif

    // Test 1: one HBARS frame.
    for (int i = 0; i < 32; i++) beat(1'b1, 2'd0, 1'b1, "t1");
    check("t1_fc1",  32'(FrameCount), 32'd1);
    check("t1_sof1", 32'(StartOfFrame), 32'd1);

    // Test 2: Mode=1 requested mid-frame, HBARS stays until wrap.
    for (int i = 0; i < 10; i++) beat(1'b1, 2'd0, 1'b1, "t2a");
    for (int i = 0; i < 22; i++) beat(1'b1, 2'd1, 1'b1, "t2b");
    // VBARS frame; request CHECKER for the following one.
    for (int i = 0; i < 32; i++) begin
      beat(1'b1, 2'd2, 1'b1, "t2v");
`ifndef PATGEN_BORDER_EN
      if (m_row == 1 && m_col == 6) check("t2_col6", 32'(video), 32'(P3));
`endif
    end

    // Test 3: CHECKER frame; request SOLID next.
    for (int i = 0; i < 32; i++) begin
      beat(1'b1, 2'd3, 1'b1, "t3");
`ifndef PATGEN_BORDER_EN
      if (m_row == 0 && m_col == 2) check("t3_r0c2", 32'(video), 32'(P1));
      if (m_row == 2 && m_col == 2) check("t3_r2c2", 32'(video), 32'(P0));
`endif
    end

    // Test 4/5: SOLID frames, with VideoReady 1,0,0,1 stalls mid-frame.
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 32; i++) begin
        if (f == 0 && i == 5) begin
          beat(1'b1, 2'd3, 1'b1, "t5a");
          beat(1'b0, 2'd3, 1'b1, "t5b");
          beat(1'b0, 2'd3, 1'b1, "t5c");
        end else begin
          beat(1'b1, 2'd3, 1'b1, "t4");
        end
      end
    end
    check("t4_fc9", 32'(FrameCount), 32'd9);

    // FrameCount wrap: run to 255, then one more frame -> 0.
    for (int f = 0; f < 246; f++)
      for (int i = 0; i < 32; i++) beat(1'b1, 2'd3, 1'b0, "wrap");
    check("wrap_fc255", 32'(FrameCount), 32'd255);
    for (int i = 0; i < 32; i++) beat(1'b1, 2'd3, 1'b1, "wrapf");
    check("wrap_fc0", 32'(FrameCount), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
